// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scan capture block.
//   DIGITS    : number of multiplexed digits on the scan bus
//   SEG_W     : number of segment lines {g,f,e,d,c,b,a}
//   state_e   : capture FSM states
//   SEG_TABLE : active-high segment pattern for each hex nibble, index = nibble value
package seg_scan_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned SEG_W  = 7;

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } state_e;

    // Entry [0] is the rightmost element: 3F decodes to 0, 71 decodes to F.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_capture_if.sv
// Scan bus and capture result bundle for seg_scan_capture.
//   digit_en_in  : observed one-hot digit enable, bit0 = digit 0
//   seg_in       : observed segment lines {g,f,e,d,c,b,a}
//   capture_en   : 1 = monitoring active
//   digits_out   : last committed frame, [3:0] = digit 0
//   frame_valid  : set by the first commit, cleared only by reset
//   frame_done   : one-cycle pulse per commit
//   scan_err     : sticky scan error flag
//   scan_timeout : sticky timeout flag
// master drives the scan bus and reads results; slave is the capture block.
interface seg_scan_capture_if;
    import seg_scan_pkg::*;

    logic [DIGITS-1:0]   digit_en_in;
    logic [SEG_W-1:0]    seg_in;
    logic                capture_en;
    logic [4*DIGITS-1:0] digits_out;
    logic                frame_valid;
    logic                frame_done;
    logic                scan_err;
    logic                scan_timeout;

    modport master (
        output digit_en_in, seg_in, capture_en,
        input  digits_out, frame_valid, frame_done, scan_err, scan_timeout
    );

    modport slave (
        input  digit_en_in, seg_in, capture_en,
        output digits_out, frame_valid, frame_done, scan_err, scan_timeout
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-segment to hex decoder.
//   seg_i   : active-high segment pattern {g,f,e,d,c,b,a}
//   nib_o   : decoded nibble (0 when the pattern is not recognised)
//   valid_o : 1 when seg_i is one of the 16 hex glyphs
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [3:0]       nib_o,
    output logic             valid_o
);

    always_comb begin
        nib_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_TABLE[i]) begin
                nib_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive-side monitor for a multiplexed 4-digit 7-segment scan.
// Waits for each digit dwell to settle, decodes the segments back to a nibble and
// commits complete, in-order 4-digit frames.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : seg_scan_capture_if.slave (scan inputs, capture_en, frame results and flags)
// Optional feature: define SEG_SCAN_TIMEOUT_EN to enable the dwell timeout counter and
// scan_timeout flag; otherwise scan_timeout is tied to 0.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned CNT_W          = 20,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 32'h000F_FFFF
) (
    input logic               clk,
    input logic               reset,
    seg_scan_capture_if.slave bus
);

    // Input stage
    logic [DIGITS-1:0] den_q;
    logic [DIGITS-1:0] den_prev_q;
    logic [SEG_W-1:0]  seg_q;

    // Settle tracking
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             changed;
    logic             sample;
    logic             timeout_hit;

    // Frame assembly
    state_e                 state_q, state_d;
    logic [1:0]             slot_q, slot_d;
    logic [DIGITS-1:0]      seen_q, seen_d;
    logic [DIGITS-2:0][3:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]      exp_en;

    // Results
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                scan_err_q, scan_err_d;

    // Decode
    logic [SEG_W-1:0] seg_dec;
    logic [3:0]       nib;
    logic             nib_valid;

    assign seg_dec = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

    seg7_decode u_decode (
        .seg_i   (seg_dec),
        .nib_o   (nib),
        .valid_o (nib_valid)
    );

    assign changed = (den_q != den_prev_q);
    // A change on the sample cycle itself suppresses the sample.
    assign sample  = !changed && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    assign exp_en  = DIGITS'(1) << slot_q;

    always_comb begin
        cnt_d = cnt_q;
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef SEG_SCAN_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             scan_timeout_q, scan_timeout_d;

    // Saturates at TIMEOUT_CYCLES so the flag and the return to idle fire once per stall.
    always_comb begin
        to_cnt_d    = to_cnt_q;
        timeout_hit = 1'b0;
        if (changed) begin
            to_cnt_d = '0;
        end else if (bus.capture_en && (to_cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            to_cnt_d    = to_cnt_q + 1'b1;
            timeout_hit = (to_cnt_d == CNT_W'(TIMEOUT_CYCLES));
        end
        scan_timeout_d = scan_timeout_q | timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q       <= '0;
            scan_timeout_q <= 1'b0;
        end else begin
            to_cnt_q       <= to_cnt_d;
            scan_timeout_q <= scan_timeout_d;
        end
    end

    assign bus.scan_timeout = scan_timeout_q;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign bus.scan_timeout   = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        seen_d        = seen_q;
        shadow_d      = shadow_q;
        digits_d      = digits_q;
        frame_valid_d = frame_valid_q;
        frame_done_d  = 1'b0;
        scan_err_d    = scan_err_q;

        if (!bus.capture_en || timeout_hit) begin
            state_d = StIdle;
            slot_d  = '0;
            seen_d  = '0;
        end else if (sample) begin
            unique case (state_q)
                StIdle: begin
                    if (den_q == 4'b0001) begin
                        if (nib_valid) begin
                            shadow_d[0] = nib;
                            seen_d      = 4'b0001;
                            slot_d      = 2'd1;
                            state_d     = StScan;
                        end else begin
                            scan_err_d = 1'b1;
                        end
                    end
                end
                StScan: begin
                    if ((den_q == exp_en) && nib_valid && (slot_q != 2'd3)) begin
                        shadow_d[slot_q] = nib;
                        seen_d[slot_q]   = 1'b1;
                        slot_d           = slot_q + 2'd1;
                    end else if ((den_q == exp_en) && nib_valid && (seen_q == 4'b0111)) begin
                        // Last digit goes straight to the output with the shadow slots.
                        digits_d      = {nib, shadow_q[2], shadow_q[1], shadow_q[0]};
                        frame_done_d  = 1'b1;
                        frame_valid_d = 1'b1;
                        seen_d        = '0;
                        slot_d        = '0;
                    end else begin
                        scan_err_d = 1'b1;
                        state_d    = StIdle;
                        seen_d     = '0;
                        slot_d     = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            den_q         <= '0;
            den_prev_q    <= '0;
            seg_q         <= '0;
            cnt_q         <= '0;
            state_q       <= StIdle;
            slot_q        <= '0;
            seen_q        <= '0;
            shadow_q      <= '0;
            digits_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            scan_err_q    <= 1'b0;
        end else begin
            den_q         <= bus.digit_en_in;
            den_prev_q    <= den_q;
            seg_q         <= bus.seg_in;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            slot_q        <= slot_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            frame_done_q  <= frame_done_d;
            scan_err_q    <= scan_err_d;
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.scan_err    = scan_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomised scoreboard bench for seg_scan_capture with a dwell-level reference model.
module tb_seg_scan_capture;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seg_scan_capture_if bus ();

    seg_scan_capture #(
        .SETTLE_CYCLES  (16),
        .CNT_W          (20),
        .SEG_ACTIVE_LOW (1'b0),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] pat_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model: state of the frame being assembled, judged one whole dwell at a time.
    logic [15:0] exp_q [$];
    bit          m_scan;
    int          m_slot;
    logic [3:0]  m_nib [4];
    bit          m_err;
    bit          m_valid;
    logic [3:0]  last_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit lookup(input logic [6:0] p, output logic [3:0] n);
        n = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pat_tab[i] == p) begin
                n = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [6:0] bad_pat();
        logic [6:0] p;
        logic [3:0] n;
        do p = 7'($urandom_range(0, 127)); while (lookup(p, n));
        return p;
    endfunction

    // One settled dwell with capture enabled.
    task automatic model_step(input logic [3:0] en, input logic [6:0] pat);
        logic [3:0] n;
        bit ok;
        ok = lookup(pat, n);
        if (!m_scan) begin
            if (en == 4'b0001) begin
                if (ok) begin
                    m_scan   = 1'b1;
                    m_nib[0] = n;
                    m_slot   = 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (en == (4'b0001 << m_slot) && ok) begin
            m_nib[m_slot] = n;
            if (m_slot == 3) begin
                exp_q.push_back({m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
                m_valid = 1'b1;
                m_slot  = 0;
            end else begin
                m_slot++;
            end
        end else begin
            m_err  = 1'b1;
            m_scan = 1'b0;
        end
    endtask

    // Dwells of 24+ cycles are always sampled; 12 or fewer never are.
    task automatic dwell(input logic [3:0] en, input logic [6:0] pat, input int len,
                         input bit cap);
        if (en == last_en) begin
            // Short separator so back-to-back identical enables stay distinct dwells.
            bus.digit_en_in = (last_en == 4'hF) ? 4'h0 : 4'hF;
            bus.capture_en  = cap;
            if (!cap) m_scan = 1'b0;
            repeat (6) @(posedge clk);
            #1;
        end
        bus.digit_en_in = en;
        bus.seg_in      = pat;
        bus.capture_en  = cap;
        last_en         = en;
        if (!cap) m_scan = 1'b0;
        else if (len >= 24) model_step(en, pat);
        repeat (len) @(posedge clk);
        #1;
        check("scan_err", 32'(bus.scan_err), 32'(m_err));
        check("frame_valid", 32'(bus.frame_valid), 32'(m_valid));
    endtask

    task automatic send_frame(input logic [15:0] v, input int len);
        for (int i = 0; i < 4; i++) begin
            dwell(4'b0001 << i, pat_tab[v[4*i +: 4]], len, 1'b1);
        end
    endtask

    task automatic do_reset();
        check("pending_frames", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_digits", 32'(bus.digits_out), 32'd0);
        check("rst_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_done", 32'(bus.frame_done), 32'd0);
        check("rst_err", 32'(bus.scan_err), 32'd0);
        check("rst_timeout", 32'(bus.scan_timeout), 32'd0);
        reset   = 1'b0;
        m_scan  = 1'b0;
        m_slot  = 0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        last_en = 4'h0;
    endtask

    // Monitor: every commit pulse must match the oldest expected frame.
    always @(negedge clk) begin
        logic [15:0] exp_v;
        if (!reset && bus.frame_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: digits_out=%h but no frame expected",
                         bus.digits_out);
            end else begin
                exp_v = exp_q.pop_front();
                check("commit_digits", 32'(bus.digits_out), 32'(exp_v));
                check("commit_valid", 32'(bus.frame_valid), 32'd1);
            end
        end
    end

    initial begin
        int slot;
        int r;
        int len;
        bit cap;
        logic [3:0] en;
        logic [6:0] pat;

        reset           = 1'b1;
        bus.digit_en_in = 4'h0;
        bus.seg_in      = 7'h00;
        bus.capture_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Clean frame 3210
        send_frame(16'h3210, 40);
        check("frame_3210", 32'(bus.digits_out), 32'h3210);

        // Bad pattern on digit 2 then a clean A,b,C,d frame
        dwell(4'b0001, pat_tab[0], 40, 1'b1);
        dwell(4'b0010, pat_tab[1], 40, 1'b1);
        dwell(4'b0100, 7'h00, 40, 1'b1);
        dwell(4'b1000, pat_tab[3], 40, 1'b1);
        check("hold_after_err", 32'(bus.digits_out), 32'h3210);
        send_frame(16'hDCBA, 40);
        check("frame_dcba", 32'(bus.digits_out), 32'hDCBA);

        // Out-of-order enable, then non-one-hot enable
        do_reset();
        dwell(4'b0001, pat_tab[5], 30, 1'b1);
        dwell(4'b0100, pat_tab[6], 30, 1'b1);
        do_reset();
        dwell(4'b0001, pat_tab[5], 30, 1'b1);
        dwell(4'b0011, pat_tab[6], 30, 1'b1);

        // Short dwells produce nothing; reset mid-frame clears everything
        do_reset();
        send_frame(16'h1234, 10);
        send_frame(16'h5678, 30);
        dwell(4'b0001, pat_tab[9], 30, 1'b1);
        dwell(4'b0010, pat_tab[8], 30, 1'b1);
        do_reset();

        // capture_en dropped after digit 1, then a full frame
        dwell(4'b0001, pat_tab[1], 30, 1'b1);
        dwell(4'b0010, pat_tab[2], 30, 1'b1);
        dwell(4'b0100, pat_tab[3], 30, 1'b0);
        dwell(4'b1000, pat_tab[4], 30, 1'b0);
        send_frame(16'hF0E1, 30);

        // Long stall on one enable
        dwell(4'b0010, pat_tab[7], 150, 1'b1);
`ifdef SEG_SCAN_TIMEOUT_EN
        check("timeout_set", 32'(bus.scan_timeout), 32'd1);
`else
        check("timeout_off", 32'(bus.scan_timeout), 32'd0);
`endif

        // Randomised scans with occasional faults
        do_reset();
        slot = 0;
        for (int k = 0; k < 160; k++) begin
            if (k % 40 == 39) begin
                do_reset();
                slot = 0;
            end
            r   = $urandom_range(0, 99);
            en  = 4'b0001 << slot;
            pat = pat_tab[$urandom_range(0, 15)];
            len = $urandom_range(24, 40);
            cap = 1'b1;
            if (r < 5) begin
                pat = bad_pat();
            end else if (r < 10) begin
                logic [3:0] w;
                do w = 4'($urandom_range(0, 15)); while (w == en);
                en = w;
            end else if (r < 15) begin
                len = $urandom_range(4, 12);
            end else if (r < 18) begin
                cap = 1'b0;
            end
            dwell(en, pat, len, cap);
            slot = (slot + 1) % 4;
        end

        repeat (5) @(posedge clk);
        #1;
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
